// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM encoding
// and the bit positions of the captured ALU status flags.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LI  = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int FLG_LT   = 0;
    localparam int FLG_EQ   = 1;
    localparam int FLG_GT   = 2;
    localparam int FLG_CIN  = 3;
    localparam int FLG_COUT = 4;
    localparam int FLG_OVF  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } alu_state_e;

    // Op codes that are forwarded unchanged to the external ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two combinational operand read ports, one
// combinational debug read port, one synchronous write port, async clear.
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
    assign dbg_data  = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential issue front-end for the external combinational ALU: accepts an
// instruction, reads operands, drives the ALU, captures z/flags, writes back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 10,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_c,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_c_in,
    input  logic              alu_c_out,
    input  logic              alu_lt,
    input  logic              alu_eq,
    input  logic              alu_gt,
    input  logic              alu_overflow,
    output logic [5:0]        flags,
    output logic              done,
    output logic              illegal,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output alu_state_e        dbg_state
);

    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; instr_ready is high only in S_IDLE, and a
    // valid presented while not ready is neither latched nor queued.

    alu_state_e        state, state_nxt;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic              instr_fire;
    logic [2:0]        op_in;

    assign op_in      = instr[15:13];
    assign instr_fire = instr_valid && instr_ready;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    if (is_alu_op(op_in)) begin
                        state_nxt = S_READ;
                    end else if (op_in == OP_LI) begin
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            result_q <= '0;
            alu_x    <= '0;
            alu_y    <= '0;
            alu_c    <= '0;
            flags    <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal <= instr_fire && !is_alu_op(op_in) && (op_in != OP_LI);
            if (instr_fire) begin
                instr_q <= instr;
                if (op_in == OP_LI) begin
                    result_q <= {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
                end
            end
            if (state == S_READ) begin
                alu_x <= rd_data_a;
                alu_y <= rd_data_b;
                alu_c <= instr_q[15:13];
            end
            if (state == S_EXEC) begin
                result_q <= alu_z;
                flags[FLG_LT]   <= alu_lt;
                flags[FLG_EQ]   <= alu_eq;
                flags[FLG_GT]   <= alu_gt;
                flags[FLG_CIN]  <= alu_c_in;
                flags[FLG_COUT] <= alu_c_out;
                flags[FLG_OVF]  <= alu_overflow;
            end
        end
    end

    // Write-back lands on the edge leaving S_WB, so a following READ sees it.
    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (instr_q[9:7]),
        .rd_addr_b (instr_q[6:4]),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (state == S_WB),
        .wr_addr   (instr_q[12:10]),
        .wr_data   (result_q)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the external
// combinational 16-bit ALU hooked to the alu_* ports.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_x, alu_y, alu_z;
    logic [2:0]  alu_c;
    logic        alu_c_in, alu_c_out, alu_lt, alu_eq, alu_gt, alu_overflow;
    logic [5:0]  flags;
    logic        done, illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    alu_state_e  dbg_state;

    int tests_run;
    int tests_failed;
    logic [15:0] exp_reg [8];

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .alu_c_in     (alu_c_in),
        .alu_c_out    (alu_c_out),
        .alu_lt       (alu_lt),
        .alu_eq       (alu_eq),
        .alu_gt       (alu_gt),
        .alu_overflow (alu_overflow),
        .flags        (flags),
        .done         (done),
        .illegal      (illegal),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external ALU model ----------------
    logic [16:0] sum17;
    always_comb begin
        sum17        = '0;
        alu_z        = '0;
        alu_c_in     = 1'b0;
        alu_c_out    = 1'b0;
        alu_overflow = 1'b0;
        alu_lt       = alu_x < alu_y;
        alu_eq       = alu_x == alu_y;
        alu_gt       = alu_x > alu_y;
        case (alu_c)
            3'b000: alu_z = alu_x & alu_y;
            3'b001: alu_z = alu_x | alu_y;
            3'b010: begin
                sum17        = {1'b0, alu_x} + {1'b0, alu_y};
                alu_z        = sum17[15:0];
                alu_c_out    = sum17[16];
                alu_overflow = (alu_x[15] == alu_y[15]) && (alu_z[15] != alu_x[15]);
            end
            3'b011: begin
                alu_c_in     = 1'b1;
                sum17        = {1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1;
                alu_z        = sum17[15:0];
                alu_c_out    = sum17[16];
                alu_overflow = (alu_x[15] != alu_y[15]) && (alu_z[15] != alu_x[15]);
            end
            3'b111: alu_z = {15'd0, alu_x < alu_y};
            default: alu_z = '0;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] mk_li(input logic [2:0] rd, input logic [9:0] imm);
        return {OP_LI, rd, imm};
    endfunction

    task automatic read_dbg(input logic [2:0] addr, output logic [15:0] val);
        dbg_addr = addr;
        #1;
        val = dbg_data;
    endtask

    // Issue one instruction and observe 6 cycles after the accept edge.
    task automatic issue(input logic [15:0] ins, output int done_cyc,
                         output int done_cnt, output int ill_cnt);
        int wait_cyc;
        wait_cyc = 0;
        done_cyc = 0;
        done_cnt = 0;
        ill_cnt  = 0;
        @(negedge clk);
        while (!instr_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (illegal) ill_cnt++;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            read_dbg(3'(i), v);
            check($sformatf("%s_r%0d", tag, i), {16'd0, v}, {16'd0, exp_reg[i]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc, dn, il, acc, low;
        logic [15:0] v;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr        = '0;
        dbg_addr     = '0;
        for (int i = 0; i < 8; i++) exp_reg[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_flags", {26'd0, flags}, 32'd0);
        check("rst_alu_x", {16'd0, alu_x}, 32'd0);
        check("rst_alu_c", {29'd0, alu_c}, 32'd0);
        check_regs("rst");

        // 1: load immediates
        issue(mk_li(3'd1, 10'd11), dc, dn, il);
        check("li1_done_cyc", dc, 1);
        check("li1_done_cnt", dn, 1);
        issue(mk_li(3'd2, 10'd19), dc, dn, il);
        check("li2_done_cnt", dn, 1);
        read_dbg(3'd1, v);
        check("li_r1", {16'd0, v}, 32'h000B);
        read_dbg(3'd2, v);
        check("li_r2", {16'd0, v}, 32'h0013);
        check("li_flags", {26'd0, flags}, 32'd0);

        // 2: AND with latency
        issue(mk(OP_AND, 3'd3, 3'd1, 3'd2), dc, dn, il);
        check("and_alu_c", {29'd0, alu_c}, 32'd0);
        check("and_done_cyc", dc, 3);
        check("and_done_cnt", dn, 1);
        read_dbg(3'd3, v);
        check("and_r3", {16'd0, v}, 32'h0003);
        check("and_lt", {31'd0, flags[FLG_LT]}, 32'd1);
        check("and_eq", {31'd0, flags[FLG_EQ]}, 32'd0);
        check("and_gt", {31'd0, flags[FLG_GT]}, 32'd0);

        // 3: SUB, SLT, ADD
        issue(mk(OP_SUB, 3'd4, 3'd2, 3'd1), dc, dn, il);
        read_dbg(3'd4, v);
        check("sub_r4", {16'd0, v}, 32'h0008);
        check("sub_gt", {31'd0, flags[FLG_GT]}, 32'd1);
        issue(mk(OP_SLT, 3'd5, 3'd1, 3'd2), dc, dn, il);
        check("slt_alu_c", {29'd0, alu_c}, 32'd7);
        read_dbg(3'd5, v);
        check("slt_r5", {16'd0, v}, 32'h0001);
        issue(mk(OP_ADD, 3'd6, 3'd1, 3'd2), dc, dn, il);
        read_dbg(3'd6, v);
        check("add_r6", {16'd0, v}, 32'h001E);

        // 4: rd==rs1, wrap-around with carry out
        issue(mk_li(3'd1, 10'h3FF), dc, dn, il);
        issue(mk(OP_ADD, 3'd1, 3'd1, 3'd1), dc, dn, il);
        read_dbg(3'd1, v);
        check("add_self_r1", {16'd0, v}, 32'h07FE);
        issue(mk_li(3'd7, 10'd1), dc, dn, il);
        issue(mk(OP_SUB, 3'd6, 3'd0, 3'd7), dc, dn, il);
        read_dbg(3'd6, v);
        check("sub_neg_r6", {16'd0, v}, 32'hFFFF);
        issue(mk(OP_ADD, 3'd5, 3'd6, 3'd7), dc, dn, il);
        read_dbg(3'd5, v);
        check("add_wrap_r5", {16'd0, v}, 32'h0000);
        check("add_wrap_cout", {31'd0, flags[FLG_COUT]}, 32'd1);
        check("add_wrap_flags", {26'd0, flags}, 32'h14);

        // 5: illegal op code
        exp_reg[0] = 16'h0000; exp_reg[1] = 16'h07FE; exp_reg[2] = 16'h0013;
        exp_reg[3] = 16'h0003; exp_reg[4] = 16'h0008; exp_reg[5] = 16'h0000;
        exp_reg[6] = 16'hFFFF; exp_reg[7] = 16'h0001;
        issue(mk(3'b101, 3'd1, 3'd2, 3'd3), dc, dn, il);
        check("ill_pulse", il, 1);
        check("ill_no_done", dn, 0);
        check("ill_flags", {26'd0, flags}, 32'h14);
        check_regs("ill");
        issue(mk(3'b110, 3'd2, 3'd2, 3'd3), dc, dn, il);
        check("ill110_pulse", il, 1);
        check("ill110_no_done", dn, 0);

        // 6: instr_valid held high -> one accept per 4 cycles
        acc = 0;
        low = 0;
        instr_valid = 1'b1;
        instr       = mk(OP_AND, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 16; i++) begin
            if (instr_ready) acc++;
            else low++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("hold_accepts", acc, 4);
        check("hold_ready_low", low, 12);

        // reset asserted while in EXEC
        instr_valid = 1'b1;
        instr       = mk(OP_ADD, 3'd3, 3'd1, 3'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_state", {30'd0, dbg_state}, {30'd0, S_EXEC});
        rst_n = 1'b0;
        #1;
        check("rst_exec_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("rst_exec_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst_exec_no_done", dn, 0);
        check("rst_exec_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_exec_flags", {26'd0, flags}, 32'd0);
        for (int i = 0; i < 8; i++) exp_reg[i] = '0;
        check_regs("rst_exec");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
